// File: rtl/datapath_pkg.sv
// Shared definitions for the single-bus datapath: ALU op encoding, IR field
// positions, RAM geometry and the fixed boot image held in the RAM.
package datapath_pkg;

   localparam int WORD_W    = 32;
   localparam int RAM_WORDS = 512;

   // IR field positions: Ra, Rb and Rc are 4-bit register numbers; the
   // constant field is IR[18:0], sign-extended from bit 18.
   localparam int FIELD_W = 4;
   localparam int RA_LSB  = 23;
   localparam int RB_LSB  = 19;
   localparam int RC_LSB  = 15;
   localparam int C_MSB   = 18;

   typedef enum logic [3:0] {
      ALU_NONE,
      ALU_INC,
      ALU_ADD,
      ALU_SUB,
      ALU_AND,
      ALU_OR,
      ALU_SHR,
      ALU_SHL,
      ALU_ROR,
      ALU_ROL,
      ALU_NEG,
      ALU_NOT
   } alu_op_e;

   // The RAM has no write path, so its contents are a constant image:
   // word 0 is "ld R1, $85" and word 0x85 holds the operand 2.
   function automatic logic [WORD_W-1:0] boot_word(input logic [31:0] addr);
      case (addr)
         32'h0000_0000: boot_word = 32'h0080_0085;
         32'h0000_0085: boot_word = 32'h0000_0002;
         default:       boot_word = '0;
      endcase
   endfunction

endpackage

// File: rtl/datapath_alu.sv
// Combinational ALU: A = Y, B = bus, 64-bit zero-extended result.
module datapath_alu
   import datapath_pkg::*;
(
   input  logic [3:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [63:0] result
);

   alu_op_e     op_e;
   logic [63:0] ror_w;
   logic [63:0] rol_w;

   assign op_e = alu_op_e'(op);

   // Rotates use a doubled operand so the wrapped bits fall out of one shift.
   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      ror_w  = {a, a} >> b[4:0];
      rol_w  = {a, a} << b[4:0];
      result = '0;
      case (op_e)
         ALU_INC: result = {32'b0, b + 32'd4};
         ALU_ADD: result = {32'b0, a + b};
         ALU_SUB: result = {32'b0, a - b};
         ALU_AND: result = {32'b0, a & b};
         ALU_OR:  result = {32'b0, a | b};
         ALU_SHR: result = {32'b0, a >> b[4:0]};
         ALU_SHL: result = {32'b0, a << b[4:0]};
         ALU_ROR: result = {32'b0, ror_w[31:0]};
         ALU_ROL: result = {32'b0, rol_w[63:32]};
         ALU_NEG: result = {32'b0, 32'd0 - b};
         ALU_NOT: result = {32'b0, ~b};
         default: result = '0;
      endcase
   end

endmodule

// File: rtl/datapath_reg32.sv
// Generic load-enabled register with asynchronous active-low clear.
module datapath_reg32 #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         clear,
   input  logic         en,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   // Load on enable, hold otherwise; clear forces zero at once.
   // NOTE: state is written with <= so every register samples pre-edge values.
   always_ff @(posedge clk or negedge clear) begin
      if (!clear)  q <= '0;
      else if (en) q <= d;
   end

endmodule

// File: rtl/datapath.sv
// 32-bit single-bus CPU datapath: register file, PC, IR, MAR, MDR, Y, Z,
// ALU, select-and-encode logic and a read-only word-addressed RAM.
module datapath
   import datapath_pkg::*;
#(
   parameter int RAM_DEPTH = RAM_WORDS
) (
   input  logic        clk,
   input  logic        clear,
   input  logic [31:0] preload,
   input  logic        PCout, Zlowout, MDRout, Cout, BAout, Rout,
   input  logic        PCin, IRin, MARin, MDRin, Yin, Zin, Rin,
   input  logic        Gra, Grb, Grc,
   input  logic        read,
   input  logic        IncPC, ADD, SUB, AND, OR, SHR, SHL, ROR, ROL, NEG, NOT,
   output logic [31:0] R0, R1, R2, R3, R4, R5, R6, R7,
   output logic [31:0] R8, R9, R10, R11, R12, R13, R14, R15,
   output logic [31:0] PC, IR, MAR, MDR, Hi, Lo,
   output logic [63:0] Z,
   output logic [63:0] ALUout,
   output logic [31:0] bus_mux_out,
   output logic [31:0] Mdatain,
   output logic [31:0] ram_data,
   output logic [31:0] C_sign_ext,
   output logic [15:0] Rins,
   output logic [15:0] Routs
);

   localparam int AW = $clog2(RAM_DEPTH);

   logic [31:0]        r [16];
   logic [31:0]        y;
   logic [FIELD_W-1:0] sel;
   logic [15:0]        dec;
   logic [3:0]         op;

   // Select-and-encode: OR the gated IR fields, then decode one-hot.
   assign sel = ({FIELD_W{Gra}} & IR[RA_LSB +: FIELD_W])
              | ({FIELD_W{Grb}} & IR[RB_LSB +: FIELD_W])
              | ({FIELD_W{Grc}} & IR[RC_LSB +: FIELD_W]);
   assign dec   = 16'(1) << sel;
   assign Rins  = dec & {16{Rin}};
   assign Routs = dec & {16{Rout | BAout}};

   assign C_sign_ext = {{(31 - C_MSB){IR[C_MSB]}}, IR[C_MSB:0]};

   // Upper MAR bits are ignored, so addresses wrap within the RAM.
   assign ram_data = boot_word(32'(MAR[AW-1:0]));
   assign Mdatain  = read ? ram_data : bus_mux_out;

   // No load path exists for Hi/Lo in this block.
   assign Hi = '0;
   assign Lo = '0;

   assign {R0, R1, R2, R3, R4, R5, R6, R7}       = {r[0], r[1], r[2], r[3], r[4], r[5], r[6], r[7]};
   assign {R8, R9, R10, R11, R12, R13, R14, R15} = {r[8], r[9], r[10], r[11], r[12], r[13], r[14], r[15]};

   // Bus mux: lowest-priority source assigned first, later ones override.
   always_comb begin
      bus_mux_out = preload;
      if (Cout)    bus_mux_out = C_sign_ext;
      if (Zlowout) bus_mux_out = Z[31:0];
      if (MDRout)  bus_mux_out = MDR;
      if (PCout)   bus_mux_out = PC;
      for (int i = 15; i >= 0; i--) begin
         if (Routs[i]) bus_mux_out = (i == 0 && BAout) ? 32'd0 : r[i];
      end
   end

   // ALU strobe encoder: IncPC has highest priority, NOT lowest.
   always_comb begin
      op = ALU_NONE;
      if (NOT)   op = ALU_NOT;
      if (NEG)   op = ALU_NEG;
      if (ROL)   op = ALU_ROL;
      if (ROR)   op = ALU_ROR;
      if (SHL)   op = ALU_SHL;
      if (SHR)   op = ALU_SHR;
      if (OR)    op = ALU_OR;
      if (AND)   op = ALU_AND;
      if (SUB)   op = ALU_SUB;
      if (ADD)   op = ALU_ADD;
      if (IncPC) op = ALU_INC;
   end

   datapath_alu u_alu (.op(op), .a(y), .b(bus_mux_out), .result(ALUout));

   datapath_reg32 u_pc  (.clk(clk), .clear(clear), .en(PCin),  .d(bus_mux_out), .q(PC));
   datapath_reg32 u_ir  (.clk(clk), .clear(clear), .en(IRin),  .d(bus_mux_out), .q(IR));
   datapath_reg32 u_mar (.clk(clk), .clear(clear), .en(MARin), .d(bus_mux_out), .q(MAR));
   datapath_reg32 u_mdr (.clk(clk), .clear(clear), .en(MDRin), .d(Mdatain),     .q(MDR));
   datapath_reg32 u_y   (.clk(clk), .clear(clear), .en(Yin),   .d(bus_mux_out), .q(y));
   datapath_reg32 #(.W(64)) u_z (.clk(clk), .clear(clear), .en(Zin), .d(ALUout), .q(Z));

   for (genvar g = 0; g < 16; g++) begin : g_rf
      datapath_reg32 u_r (.clk(clk), .clear(clear), .en(Rins[g]), .d(bus_mux_out), .q(r[g]));
   end

endmodule

// File: tb/tb_datapath.sv
// Self-checking bench for datapath: behavioural model + per-cycle compare,
// directed boot sequence, ALU sweep and randomized control strobes.
module tb_datapath;

   logic        clk = 1'b0;
   logic        clear;
   logic [31:0] preload;
   logic        PCout, Zlowout, MDRout, Cout, BAout, Rout;
   logic        PCin, IRin, MARin, MDRin, Yin, Zin, Rin;
   logic        Gra, Grb, Grc, read;
   logic        IncPC, ADD, SUB, AND, OR, SHR, SHL, ROR, ROL, NEG, NOT;
   logic [31:0] R0, R1, R2, R3, R4, R5, R6, R7, R8, R9, R10, R11, R12, R13, R14, R15;
   logic [31:0] PC, IR, MAR, MDR, Hi, Lo, bus_mux_out, Mdatain, ram_data, C_sign_ext;
   logic [63:0] Z, ALUout;
   logic [15:0] Rins, Routs;
   logic [31:0] dut_r [16];

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   datapath dut (
      .clk(clk), .clear(clear), .preload(preload),
      .PCout(PCout), .Zlowout(Zlowout), .MDRout(MDRout), .Cout(Cout), .BAout(BAout), .Rout(Rout),
      .PCin(PCin), .IRin(IRin), .MARin(MARin), .MDRin(MDRin), .Yin(Yin), .Zin(Zin), .Rin(Rin),
      .Gra(Gra), .Grb(Grb), .Grc(Grc), .read(read),
      .IncPC(IncPC), .ADD(ADD), .SUB(SUB), .AND(AND), .OR(OR), .SHR(SHR), .SHL(SHL),
      .ROR(ROR), .ROL(ROL), .NEG(NEG), .NOT(NOT),
      .R0(R0), .R1(R1), .R2(R2), .R3(R3), .R4(R4), .R5(R5), .R6(R6), .R7(R7),
      .R8(R8), .R9(R9), .R10(R10), .R11(R11), .R12(R12), .R13(R13), .R14(R14), .R15(R15),
      .PC(PC), .IR(IR), .MAR(MAR), .MDR(MDR), .Hi(Hi), .Lo(Lo),
      .Z(Z), .ALUout(ALUout), .bus_mux_out(bus_mux_out), .Mdatain(Mdatain),
      .ram_data(ram_data), .C_sign_ext(C_sign_ext), .Rins(Rins), .Routs(Routs)
   );

   assign dut_r = '{R0, R1, R2, R3, R4, R5, R6, R7, R8, R9, R10, R11, R12, R13, R14, R15};

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [31:0] m_r [16];
   logic [31:0] m_pc, m_ir, m_mar, m_mdr, m_y;
   logic [63:0] m_z;

   function automatic int m_sel();
      int s = 0;
      if (Gra) s = s | int'(m_ir[26:23]);
      if (Grb) s = s | int'(m_ir[22:19]);
      if (Grc) s = s | int'(m_ir[18:15]);
      return s;
   endfunction

   function automatic logic [31:0] m_csx();
      return 32'($signed(m_ir[18:0]));
   endfunction

   function automatic logic [31:0] m_ram();
      int a = int'(m_mar % 512);
      if (a == 0)     return 32'h0080_0085;
      if (a == 'h85)  return 32'h0000_0002;
      return 32'h0;
   endfunction

   function automatic logic [31:0] m_bus();
      int s = m_sel();
      if (Rout || BAout) return (s == 0 && BAout) ? 32'h0 : m_r[s];
      if (PCout)   return m_pc;
      if (MDRout)  return m_mdr;
      if (Zlowout) return m_z[31:0];
      if (Cout)    return m_csx();
      return preload;
   endfunction

   function automatic logic [63:0] m_alu();
      logic [31:0] a = m_y;
      logic [31:0] b = m_bus();
      logic [31:0] res;
      int n = int'(b[4:0]);
      if (IncPC)    res = b + 32'd4;
      else if (ADD) res = a + b;
      else if (SUB) res = a - b;
      else if (AND) res = a & b;
      else if (OR)  res = a | b;
      else if (SHR) res = a >> n;
      else if (SHL) res = a << n;
      else if (ROR) res = (a >> n) | (a << (32 - n));
      else if (ROL) res = (a << n) | (a >> (32 - n));
      else if (NEG) res = 32'd0 - b;
      else if (NOT) res = ~b;
      else          res = 32'd0;
      return {32'h0, res};
   endfunction

   function automatic logic [15:0] m_onehot(input logic en);
      return en ? 16'(1 << m_sel()) : 16'h0;
   endfunction

   // Model state update: async clear, otherwise load what is enabled.
   always @(posedge clk or negedge clear) begin
      if (!clear) begin
         for (int i = 0; i < 16; i++) m_r[i] <= '0;
         m_pc <= '0; m_ir <= '0; m_mar <= '0; m_mdr <= '0; m_y <= '0; m_z <= '0;
      end else begin
         if (Rin)   m_r[m_sel()] <= m_bus();
         if (PCin)  m_pc  <= m_bus();
         if (IRin)  m_ir  <= m_bus();
         if (MARin) m_mar <= m_bus();
         if (Yin)   m_y   <= m_bus();
         if (MDRin) m_mdr <= read ? m_ram() : m_bus();
         if (Zin)   m_z   <= m_alu();
      end
   end

   // Compare every observable output against the model on each falling edge.
   always @(negedge clk) begin
      for (int i = 0; i < 16; i++) check($sformatf("R%0d", i), dut_r[i], m_r[i]);
      check("PC", PC, m_pc);
      check("IR", IR, m_ir);
      check("MAR", MAR, m_mar);
      check("MDR", MDR, m_mdr);
      check("Z", Z, m_z);
      check("Hi", Hi, 64'h0);
      check("Lo", Lo, 64'h0);
      check("bus", bus_mux_out, m_bus());
      check("ALUout", ALUout, m_alu());
      check("ram_data", ram_data, m_ram());
      check("Mdatain", Mdatain, read ? m_ram() : m_bus());
      check("C_sign_ext", C_sign_ext, m_csx());
      check("Rins", Rins, m_onehot(Rin));
      check("Routs", Routs, m_onehot(Rout | BAout));
   end

   // ---------------- stimulus ----------------
   task automatic idle();
      {PCout, Zlowout, MDRout, Cout, BAout, Rout} = '0;
      {PCin, IRin, MARin, MDRin, Yin, Zin, Rin} = '0;
      {Gra, Grb, Grc, read} = '0;
      {IncPC, ADD, SUB, AND, OR, SHR, SHL, ROR, ROL, NEG, NOT} = '0;
   endtask

   task automatic rand_inputs();
      int k;
      idle();
      preload = $urandom;
      if ($urandom_range(2) == 0) preload[8:0] = ($urandom_range(1) == 1) ? 9'h085 : 9'h000;
      PCout   = ($urandom_range(7) == 0);
      Zlowout = ($urandom_range(7) == 0);
      MDRout  = ($urandom_range(7) == 0);
      Cout    = ($urandom_range(7) == 0);
      BAout   = ($urandom_range(7) == 0);
      Rout    = ($urandom_range(5) == 0);
      PCin    = ($urandom_range(3) == 0);
      IRin    = ($urandom_range(3) == 0);
      MARin   = ($urandom_range(3) == 0);
      MDRin   = ($urandom_range(3) == 0);
      Yin     = ($urandom_range(3) == 0);
      Zin     = ($urandom_range(2) == 0);
      Rin     = ($urandom_range(2) == 0);
      Gra     = ($urandom_range(1) == 0);
      Grb     = ($urandom_range(1) == 0);
      Grc     = ($urandom_range(1) == 0);
      read    = ($urandom_range(1) == 0);
      k = $urandom_range(13);
      if (k <= 10)      {IncPC, ADD, SUB, AND, OR, SHR, SHL, ROR, ROL, NEG, NOT} = 11'(1 << k);
      else if (k >= 12) {IncPC, ADD, SUB, AND, OR, SHR, SHL, ROR, ROL, NEG, NOT} = 11'($urandom);
   endtask

   // ALU sweep table with Y = 0x80000001, bus = 4; mask bit 10 = IncPC .. bit 0 = NOT.
   logic [10:0] sw_mask [14];
   logic [63:0] sw_exp  [14];

   initial begin
      sw_mask = '{11'h400, 11'h200, 11'h100, 11'h080, 11'h040, 11'h020, 11'h010,
                  11'h008, 11'h004, 11'h002, 11'h001, 11'h7FF, 11'h101, 11'h000};
      sw_exp  = '{64'h8, 64'h80000005, 64'h7FFFFFFD, 64'h0, 64'h80000005, 64'h08000000, 64'h10,
                  64'h18000000, 64'h18, 64'hFFFFFFFC, 64'hFFFFFFFB, 64'h8, 64'h7FFFFFFD, 64'h0};

      clear = 1'b0;
      preload = '0;
      idle();
      #13 clear = 1'b1;

      // Instruction fetch and "ld R1, $85"
      @(posedge clk); #2;
      PCout = 1; MARin = 1; IncPC = 1; Zin = 1;
      @(posedge clk); #1;
      check("t0_mar", MAR, 64'h0);
      check("t0_z", Z, 64'h4);
      #1 idle(); Zlowout = 1; PCin = 1; read = 1; MDRin = 1;
      @(posedge clk); #1;
      check("t1_pc", PC, 64'h4);
      check("t1_mdr", MDR, 64'h0080_0085);
      #1 idle(); MDRout = 1; IRin = 1;
      @(posedge clk); #1;
      check("t2_ir", IR, 64'h0080_0085);
      check("t2_csx", C_sign_ext, 64'h85);
      #1 idle(); Grb = 1; BAout = 1; Yin = 1;
      #1;
      check("t3_routs", Routs, 64'h0001);
      check("t3_bus", bus_mux_out, 64'h0);
      @(posedge clk); #2;
      idle(); Cout = 1; ADD = 1; Zin = 1;
      #1 check("t4_alu", ALUout, 64'h85);
      @(posedge clk); #1;
      check("t4_z", Z, 64'h85);
      #1 idle(); Zlowout = 1; MARin = 1;
      @(posedge clk); #1;
      check("t5_mar", MAR, 64'h85);
      check("t5_ram", ram_data, 64'h2);
      #1 idle(); read = 1; MDRin = 1;
      @(posedge clk); #1;
      check("t6_mdr", MDR, 64'h2);
      #1 idle(); MDRout = 1; Gra = 1; Rin = 1;
      #1 check("t7_rins", Rins, 64'h0002);
      @(posedge clk); #1;
      check("t7_r1", R1, 64'h2);

      // ALU sweep
      #1 idle(); preload = 32'h8000_0001; Yin = 1;
      for (int i = 0; i < 14; i++) begin
         @(posedge clk); #2;
         idle(); preload = 32'h4;
         {IncPC, ADD, SUB, AND, OR, SHR, SHL, ROR, ROL, NEG, NOT} = sw_mask[i];
         #1 check($sformatf("alu_sweep_%0d", i), ALUout, sw_exp[i]);
      end

      // No bus source: preload reaches the bus
      @(posedge clk); #2;
      idle(); preload = 32'hDEAD_BEEF;
      #1 check("preload_bus", bus_mux_out, 64'hDEAD_BEEF);

      // Randomized control strobes
      for (int c = 0; c < 600; c++) begin
         @(posedge clk); #2;
         rand_inputs();
      end

      // Mid-cycle asynchronous clear
      @(posedge clk); #2;
      idle();
      clear = 1'b0;
      #1;
      for (int i = 0; i < 16; i++) check($sformatf("rst_R%0d", i), dut_r[i], 64'h0);
      check("rst_PC", PC, 64'h0);
      check("rst_IR", IR, 64'h0);
      check("rst_MAR", MAR, 64'h0);
      check("rst_MDR", MDR, 64'h0);
      check("rst_Z", Z, 64'h0);
      @(posedge clk); #2;
      clear = 1'b1;

      for (int c = 0; c < 200; c++) begin
         @(posedge clk); #2;
         rand_inputs();
      end

      @(posedge clk); #2;
      idle();
      @(posedge clk); #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
